ov7670_capture_param: RTL and testbench

Parametrised capture front end for the OV7670 camera: pairs the 8-bit pixel bus into 16-bit RGB565 pixels and converts them to the selected output format. It applies optional 2-D decimation and writes pixels to the frame buffer through a single write port (addr/dout/we). It runs in the camera pixel clock domain, between the camera pins and the dual-port frame buffer. It adds the following to the current capture path:
- frame sequencing
- an enable gate
- address-range protection
- line-length checking
- a frame-done strobe

---
 rtl/ov7670_capture_param.sv | 175 +++++++++++++++++
 tb/tb_ov7670_capture_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_param.sv
// OV7670 capture front end: assembles byte pairs into RGB565 pixels, converts
// to the configured output format, decimates, and writes them to the frame buffer.
module ov7670_capture_param #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 1,
    parameter int FMT      = 0,
    parameter int PIX_W    = 12,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  dout,
    output logic              we,
    output logic              frame_done,
    output logic              line_err,
    output logic              ovf
);

    localparam int MAX_ADDR_I = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM) - 1;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_I);
    localparam int COL_W = $clog2(H_ACTIVE) + 2;
    localparam int ROW_W = $clog2(V_ACTIVE) + 2;
    localparam int BC_W  = $clog2(2 * H_ACTIVE + 1) + 1;
    localparam logic [BC_W-1:0]  LINE_BYTES = BC_W'(2 * H_ACTIVE);
    localparam logic [COL_W-1:0] COL_MASK   = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] ROW_MASK   = ROW_W'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE
    } state_t;

    state_t state, state_next;

    logic              vsync_d;
    logic              href_d;
    logic              phase;
    logic [7:0]        hi_byte;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BC_W-1:0]   byte_cnt;
    logic              full;
    logic [15:0]       pixel;
    logic [PIX_W-1:0]  pix_conv;

    logic vsync_fall;
    logic href_fall;
    logic frame_start;
    logic active_byte;
    logic pix_done;
    logic store_hit;

    assign pixel = {hi_byte, d};

    generate
        if (FMT == 0) begin : g_rgb444
            logic unused_pix;
            assign unused_pix = ^{pixel[11], pixel[6:5], pixel[0]};
            assign pix_conv   = PIX_W'({pixel[15:12], pixel[10:7], pixel[4:1]});
        end else begin : g_rgb565
            assign pix_conv = PIX_W'(pixel);
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IDLE waits for blanking so capture never starts mid-frame.
    always_comb begin
        state_next  = state;
        vsync_fall  = vsync_d & ~vsync;
        href_fall   = href_d & ~href;
        active_byte = (state == ACTIVE) && !vsync && href;
        pix_done    = active_byte && phase;
        store_hit   = pix_done && ((col & COL_MASK) == '0) && ((row & ROW_MASK) == '0);
        case (state)
            IDLE:    if (vsync) state_next = SYNC;
            SYNC:    if (vsync_fall && enable) state_next = ACTIVE;
            ACTIVE:  if (vsync) state_next = SYNC;
            default: state_next = IDLE;
        endcase
        frame_start = (state == SYNC) && (state_next == ACTIVE);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            col        <= '0;
            row        <= '0;
            byte_cnt   <= '0;
            full       <= 1'b0;
            addr       <= '0;
            dout       <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            href_d     <= href;
            we         <= 1'b0;
            frame_done <= (state == ACTIVE) && vsync;
            phase      <= active_byte ? ~phase : 1'b0;

            if (active_byte && !phase) begin
                hi_byte <= d;
            end

            // Byte count saturates so arbitrarily long lines still flag an error.
            if (frame_start || !href) begin
                byte_cnt <= '0;
            end else if (active_byte && (byte_cnt != '1)) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (frame_start || !href) begin
                col <= '0;
            end else if (pix_done) begin
                col <= col + 1'b1;
            end

            if (frame_start) begin
                row <= '0;
            end else if ((state == ACTIVE) && href_fall) begin
                row <= row + 1'b1;
            end

            if (frame_start) begin
                line_err <= 1'b0;
            end else if ((state == ACTIVE) && href_fall && (byte_cnt != LINE_BYTES)) begin
                line_err <= 1'b1;
            end

            // addr advances after each write; once the last slot is used it
            // stays there and later stores only raise ovf.
            if (frame_start) begin
                addr <= '0;
                full <= 1'b0;
                ovf  <= 1'b0;
            end else begin
                if (we) begin
                    if (addr == MAX_ADDR) begin
                        full <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                if (store_hit) begin
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        we   <= 1'b1;
                        dout <= pix_conv;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture_param.sv
// Directed bench for ov7670_capture_param: three parameterisations share one
// camera stimulus stream; writes and frame_done pulses are logged on negedge.
module tb_ov7670_capture_param;

    logic       pclk;
    logic       rst_n;
    logic       vsync;
    logic       href;
    logic       enable;
    logic [7:0] d;

    logic [2:0]  addr0;
    logic [11:0] dout0;
    logic        we0, frame_done0, line_err0, ovf0;
    logic [2:0]  addr1;
    logic [15:0] dout1;
    logic        we1, frame_done1, line_err1, ovf1;
    logic [1:0]  addr2;
    logic [15:0] dout2;
    logic        we2, frame_done2, line_err2, ovf2;

    int checks   = 0;
    int failures = 0;
    int wc0 = 0, wc1 = 0, wc2 = 0;
    int fd0 = 0, fd1 = 0, fd2 = 0;
    int run_err = 0;
    logic we0_q = 1'b0, we1_q = 1'b0, we2_q = 1'b0;

    logic [2:0]  addr_log0 [0:31];
    logic [11:0] dout_log0 [0:31];
    logic [15:0] dout_log1 [0:31];
    logic [1:0]  addr_log2 [0:31];
    logic [15:0] dout_log2 [0:31];
    logic [15:0] decim_exp [0:3];

    ov7670_capture_param #(
        .H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .FMT(0), .PIX_W(12), .ADDR_W(3)
    ) dut0 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .addr(addr0), .dout(dout0), .we(we0), .frame_done(frame_done0),
        .line_err(line_err0), .ovf(ovf0)
    );

    ov7670_capture_param #(
        .H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .FMT(1), .PIX_W(16), .ADDR_W(3)
    ) dut1 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .addr(addr1), .dout(dout1), .we(we1), .frame_done(frame_done1),
        .line_err(line_err1), .ovf(ovf1)
    );

    ov7670_capture_param #(
        .H_ACTIVE(4), .V_ACTIVE(4), .DECIM(2), .FMT(1), .PIX_W(16), .ADDR_W(2)
    ) dut2 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .enable(enable),
        .addr(addr2), .dout(dout2), .we(we2), .frame_done(frame_done2),
        .line_err(line_err2), .ovf(ovf2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Write/frame_done logger; also catches any we held for two cycles.
    always @(negedge pclk) begin
        if (we0) begin
            if (wc0 < 32) begin
                addr_log0[wc0] <= addr0;
                dout_log0[wc0] <= dout0;
            end
            wc0 <= wc0 + 1;
        end
        if (we1) begin
            if (wc1 < 32) dout_log1[wc1] <= dout1;
            wc1 <= wc1 + 1;
        end
        if (we2) begin
            if (wc2 < 32) begin
                addr_log2[wc2] <= addr2;
                dout_log2[wc2] <= dout2;
            end
            wc2 <= wc2 + 1;
        end
        if ((we0 && we0_q) || (we1 && we1_q) || (we2 && we2_q)) run_err <= run_err + 1;
        we0_q <= we0;
        we1_q <= we1;
        we2_q <= we2;
        fd0 <= fd0 + int'(frame_done0);
        fd1 <= fd1 + int'(frame_done1);
        fd2 <= fd2 + int'(frame_done2);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge pclk);
        href = 1'b1;
        d    = b;
    endtask

    task automatic end_line();
        @(negedge pclk);
        href = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic apply_stimulus(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < nbytes; i++) push_byte((i % 2 == 0) ? b0 : b1);
        end_line();
    endtask

    task automatic vsync_high();
        @(negedge pclk);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic vsync_low();
        @(negedge pclk);
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic clear_logs();
        @(posedge pclk);
        wc0 = 0; wc1 = 0; wc2 = 0;
        fd0 = 0; fd1 = 0; fd2 = 0;
    endtask

    initial begin
        decim_exp[0] = 16'h0055;
        decim_exp[1] = 16'h0255;
        decim_exp[2] = 16'h2055;
        decim_exp[3] = 16'h2255;
        rst_n  = 1'b1;
        vsync  = 1'b0;
        href   = 1'b0;
        d      = 8'h00;
        enable = 1'b1;

        repeat (2) @(negedge pclk);
        rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        check_output("reset_dut0", {addr0, dout0, we0, frame_done0, line_err0, ovf0}, 32'h0);
        check_output("reset_dut1", {addr1, dout1, we1, frame_done1, line_err1, ovf1}, 32'h0);
        check_output("reset_dut2", {addr2, dout2, we2, frame_done2, line_err2, ovf2}, 32'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);

        $display("[TB] frame 1: basic RGB444 capture");
        vsync_high();
        clear_logs();
        vsync_low();
        apply_stimulus(8, 8'hF0, 8'h0F);
        apply_stimulus(8, 8'hF0, 8'h0F);
        vsync_high();
        check_output("f1_we_count", wc0, 8);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("f1_addr%0d", i), 32'(addr_log0[i]), i);
            check_output($sformatf("f1_dout%0d", i), 32'(dout_log0[i]), 32'hF07);
        end
        check_output("f1_frame_done", fd0, 1);
        check_output("f1_line_err", 32'(line_err0), 0);
        check_output("f1_ovf", 32'(ovf0), 0);
        check_output("f1_addr_hold", 32'(addr0), 7);
        check_output("f1_decim_rows01", wc2, 2);

        $display("[TB] frame 2: RGB565 pass-through and write latency");
        clear_logs();
        vsync_low();
        push_byte(8'hAB);
        push_byte(8'hCD);
        @(posedge pclk);
        #1;
        check_output("f2_lat_we", 32'(we1), 1);
        check_output("f2_lat_dout", 32'(dout1), 32'hABCD);
        check_output("f2_lat_addr", 32'(addr1), 0);
        for (int i = 0; i < 3; i++) begin
            push_byte(8'hAB);
            push_byte(8'hCD);
        end
        end_line();
        vsync_high();
        check_output("f2_we_count", wc1, 4);
        check_output("f2_dout_last", 32'(dout_log1[3]), 32'hABCD);
        check_output("f2_frame_done", fd1, 1);

        $display("[TB] frame 3: 2x decimation over a 4x4 frame");
        clear_logs();
        vsync_low();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                push_byte(8'(r * 16 + c));
                push_byte(8'h55);
            end
            end_line();
        end
        vsync_high();
        check_output("f3_decim_count", wc2, 4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("f3_decim_addr%0d", i), 32'(addr_log2[i]), i);
            check_output($sformatf("f3_decim_dout%0d", i), 32'(dout_log2[i]), 32'(decim_exp[i]));
        end
        check_output("f3_decim_ovf", 32'(ovf2), 0);
        check_output("f3_decim_line_err", 32'(line_err2), 0);
        check_output("f3_full_ovf", 32'(ovf0), 1);
        check_output("f3_full_addr", 32'(addr0), 7);

        $display("[TB] frame 4: short line of three bytes");
        clear_logs();
        vsync_low();
        apply_stimulus(3, 8'hF0, 8'h0F);
        check_output("f4_line_err_set", 32'(line_err0), 1);
        apply_stimulus(8, 8'hF0, 8'h0F);
        apply_stimulus(8, 8'hF0, 8'h0F);
        vsync_high();
        check_output("f4_we_count", wc0, 8);
        check_output("f4_dout_first", 32'(dout_log0[0]), 32'hF07);
        check_output("f4_dout_realigned", 32'(dout_log0[1]), 32'hF07);
        check_output("f4_line_err_sticky", 32'(line_err0), 1);

        $display("[TB] frame 5: extra line beyond V_ACTIVE");
        clear_logs();
        vsync_low();
        check_output("f5_line_err_clear", 32'(line_err0), 0);
        check_output("f5_ovf_clear", 32'(ovf0), 0);
        check_output("f5_addr_clear", 32'(addr0), 0);
        apply_stimulus(8, 8'hF0, 8'h0F);
        apply_stimulus(8, 8'hF0, 8'h0F);
        apply_stimulus(8, 8'hF0, 8'h0F);
        vsync_high();
        check_output("f5_we_count", wc0, 8);
        check_output("f5_last_addr", 32'(addr_log0[7]), 7);
        check_output("f5_no_wrap", 32'(addr0), 7);
        check_output("f5_ovf_set", 32'(ovf0), 1);
        check_output("f5_line_err", 32'(line_err0), 0);

        $display("[TB] frame 6: capture disabled at frame start");
        clear_logs();
        enable = 1'b0;
        vsync_low();
        apply_stimulus(8, 8'hF0, 8'h0F);
        apply_stimulus(8, 8'hF0, 8'h0F);
        vsync_high();
        enable = 1'b1;
        check_output("f6_no_we", wc0 + wc1 + wc2, 0);
        check_output("f6_no_frame_done", fd0 + fd1 + fd2, 0);

        $display("[TB] frame 7: reset mid-line");
        clear_logs();
        vsync_low();
        for (int i = 0; i < 3; i++) begin
            push_byte(8'hF0);
            push_byte(8'h0F);
        end
        @(negedge pclk);
        check_output("f7_pre_reset_addr", 32'(addr0), 2);
        check_output("f7_pre_reset_we", 32'(we0), 1);
        rst_n = 1'b0;
        #1;
        check_output("f7_reset_dut0", {addr0, dout0, we0, frame_done0, line_err0, ovf0}, 32'h0);
        check_output("f7_reset_dut1", {addr1, dout1, we1, frame_done1, line_err1, ovf1}, 32'h0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        clear_logs();
        apply_stimulus(8, 8'hF0, 8'h0F);
        @(negedge pclk);
        vsync = 1'b1;
        apply_stimulus(8, 8'hF0, 8'h0F);
        vsync_low();
        check_output("f7_no_write_before_sync", wc0, 0);
        apply_stimulus(8, 8'hF0, 8'h0F);
        check_output("f7_resume_count", wc0, 4);
        check_output("f7_resume_addr3", 32'(addr_log0[3]), 3);
        vsync_high();
        check_output("f7_frame_done", fd0, 1);

        check_output("we_single_cycle", run_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
